// File: rtl/bcd_display_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_display_counter_if
//  Description : Control/status bundle for bcd_display_counter.
//                master drives the count controls and receives the BCD value,
//                the wrap pulse and the multiplexed 7-segment pins; slave is
//                the counter side.
//  Signals     : en, up_dn, clear, load, load_val[4*DIGITS-1:0]  (master->slave)
//                bcd[4*DIGITS-1:0], wrap, an[DIGITS-1:0], sseg[7:0] (slave->master)
//  Revision    : 1.0  initial release
// ============================================================================
interface bcd_display_counter_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  up_dn;
    logic                  clear;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   bcd;
    logic                  wrap;
    logic [DIGITS-1:0]     an;
    logic [7:0]            sseg;

    modport master (
        output en, up_dn, clear, load, load_val,
        input  bcd, wrap, an, sseg
    );

    modport slave (
        input  en, up_dn, clear, load, load_val,
        output bcd, wrap, an, sseg
    );
endinterface
`default_nettype wire

// File: rtl/bcd_display_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_display_counter
//  Description : DIGITS-decade BCD up/down counter with count-rate prescaler,
//                parallel load, synchronous clear and a multiplexed
//                common-anode 7-segment driver with optional leading-zero
//                blanking.
//  Ports       : clk      - system clock, rising edge
//                reset_n  - synchronous active-low reset
//                bus_io   - slave modport: en, up_dn, clear, load, load_val
//                           in; bcd, wrap, an (active-low), sseg (active-low,
//                           [6:0]=g..a, [7]=dp) out
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_display_counter #(
    parameter int DIGITS      = 4,
    parameter int TICK_DIV    = 10_000_000,
    parameter int REFRESH_DIV = 100_000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  wire logic                clk,
    input  wire logic                reset_n,
    bcd_display_counter_if.slave     bus_io
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_PRE_W = (TICK_DIV > 1)    ? $clog2(TICK_DIV)    : 1;
    localparam int c_REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_SEL_W = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;

    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);
    localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_DIV - 1);
    localparam logic [c_SEL_W-1:0] c_SEL_LAST = c_SEL_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0]  c_AN_RESET = ~DIGITS'(1);
    localparam logic [7:0]         c_SEG_BLANK = 8'hFF;

    // ------------------------------------------------------------------------
    // Registers and combinational nets
    // ------------------------------------------------------------------------
    logic [c_PRE_W-1:0] pre_q, pre_d;
    logic [c_BCD_W-1:0] bcd_q, bcd_d;
    logic               wrap_q, wrap_d;
    logic [c_REF_W-1:0] refresh_q, refresh_d;
    logic [c_SEL_W-1:0] sel_q, sel_d;
    logic [DIGITS-1:0]  an_q, an_d;
    logic [7:0]         sseg_q, sseg_d;

    logic               tick;
    logic [c_BCD_W-1:0] load_clamped;
    logic [c_BCD_W-1:0] stepped;
    logic               step_carry;
    logic               refresh_last;
    logic [DIGITS-1:0]  zero_from;
    logic               zero_acc;
    logic [3:0]         sel_digit;
    logic               sel_blank;

    // ------------------------------------------------------------------------
    // Active-low segment decode, dp forced off
    // ------------------------------------------------------------------------
    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = c_SEG_BLANK;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------------
    // Load value clamp: any non-decimal nibble is forced to 9 so the counter
    // never holds an invalid BCD code.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_clamp
        assign load_clamped[4*gi +: 4] =
            (bus_io.load_val[4*gi +: 4] > 4'd9) ? 4'd9 : bus_io.load_val[4*gi +: 4];
    end

    // ------------------------------------------------------------------------
    // One BCD step. A carry/borrow of 1 is injected into digit 0 and ripples
    // upward through every digit sitting at its limit (9 up, 0 down). A carry
    // that survives past the top digit means the whole count wrapped.
    // ------------------------------------------------------------------------
    always_comb begin
        stepped    = bcd_q;
        step_carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (step_carry) begin
                if (bus_io.up_dn) begin
                    if (bcd_q[4*i +: 4] == 4'd9) begin
                        stepped[4*i +: 4] = 4'd0;
                    end else begin
                        stepped[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                        step_carry        = 1'b0;
                    end
                end else begin
                    if (bcd_q[4*i +: 4] == 4'd0) begin
                        stepped[4*i +: 4] = 4'd9;
                    end else begin
                        stepped[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
                        step_carry        = 1'b0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Prescaler and counter next state: clear > load > tick > hold
    // ------------------------------------------------------------------------
    assign tick = bus_io.en && (pre_q == c_PRE_LAST);

    always_comb begin
        pre_d  = pre_q;
        bcd_d  = bcd_q;
        wrap_d = 1'b0;
        if (bus_io.clear) begin
            pre_d = '0;
            bcd_d = '0;
        end else if (bus_io.load) begin
            pre_d = '0;
            bcd_d = load_clamped;
        end else if (bus_io.en) begin
            // en low leaves pre_q untouched so a paused period resumes intact
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                bcd_d  = stepped;
                wrap_d = step_carry;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Scan timing: free-running, unaffected by en/clear/load
    // ------------------------------------------------------------------------
    assign refresh_last = (refresh_q == c_REF_LAST);

    always_comb begin
        refresh_d = refresh_last ? '0 : refresh_q + 1'b1;
        sel_d     = sel_q;
        if (refresh_last) begin
            sel_d = (sel_q == c_SEL_LAST) ? '0 : sel_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Display next state. zero_from[i] is set when digit i and every digit
    // above it are zero; that is exactly the leading-zero condition.
    // ------------------------------------------------------------------------
    always_comb begin
        zero_from = '0;
        zero_acc  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_acc     = zero_acc && (bcd_q[4*i +: 4] == 4'd0);
            zero_from[i] = zero_acc;
        end

        an_d      = '1;
        sel_digit = 4'd0;
        sel_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_q == c_SEL_W'(i)) begin
                an_d[i]   = 1'b0;
                sel_digit = bcd_q[4*i +: 4];
                // digit 0 always shows, so a zero count still reads "0"
                sel_blank = BLANK_LZ && (i != 0) && zero_from[i];
            end
        end

        sseg_d = sel_blank ? c_SEG_BLANK : seg_decode(sel_digit);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pre_q     <= '0;
            bcd_q     <= '0;
            wrap_q    <= 1'b0;
            refresh_q <= '0;
            sel_q     <= '0;
            an_q      <= c_AN_RESET;
            sseg_q    <= 8'hC0;
        end else begin
            pre_q     <= pre_d;
            bcd_q     <= bcd_d;
            wrap_q    <= wrap_d;
            refresh_q <= refresh_d;
            sel_q     <= sel_d;
            an_q      <= an_d;
            sseg_q    <= sseg_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus_io.bcd  = bcd_q;
    assign bus_io.wrap = wrap_q;
    assign bus_io.an   = an_q;
    assign bus_io.sseg = sseg_q;

endmodule
`default_nettype wire
